// File: rtl/clock_pkg.sv
// Shared alarm-clock definitions: entry FSM states, BCD time limits and the midnight value.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_COMMIT
    } state_t;

    localparam logic [3:0]  MAX_H1       = 4'd2;
    localparam logic [3:0]  MAX_H0_AT_20 = 4'd3;
    localparam logic [3:0]  MAX_M1       = 4'd5;
    localparam logic [3:0]  MAX_DIGIT    = 4'd9;
    localparam logic [15:0] MIDNIGHT     = 16'h0000;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational HH:MM validity check on a packed BCD word {H1,H0,M1,M0}.
module bcd_time_check
    import clock_pkg::*;
(
    input  logic [15:0] bcd_i,
    output logic        valid_o
);

    logic [3:0] h1, h0, m1, m0;
    logic       hours_ok, mins_ok;

    assign h1 = bcd_i[15:12];
    assign h0 = bcd_i[11:8];
    assign m1 = bcd_i[7:4];
    assign m0 = bcd_i[3:0];

    // 20-23 is the only tens-of-hours value that narrows the units digit
    assign hours_ok = (h1 <= MAX_H1) && (h0 <= MAX_DIGIT) &&
                      ((h1 != MAX_H1) || (h0 <= MAX_H0_AT_20));
    assign mins_ok  = (m1 <= MAX_M1) && (m0 <= MAX_DIGIT);
    assign valid_o  = hours_ok && mins_ok;

endmodule

// File: rtl/time_entry_loader.sv
// Keypad HH:MM entry buffer with range check; issues one-cycle time/alarm load strobes.
module time_entry_loader
    import clock_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_second,
    input  logic [3:0]  key,
    input  logic        key_valid,
    input  logic        time_button,
    input  logic        alarm_button,
    input  logic        clear_button,
    output logic [15:0] key_buffer,
    output logic [15:0] set_data,
    output logic        load_time,
    output logic        load_alarm,
    output logic        entry_active,
    output logic        entry_error
);

    localparam logic [3:0] TIMEOUT_LIM = TIMEOUT_SEC[3:0];

    state_t      state_q;
    logic [15:0] buf_q;
    logic [15:0] set_data_q;
    logic [2:0]  digits_q;
    logic [3:0]  tmo_q;
    logic        tgt_alarm_q;
    logic        load_time_q, load_alarm_q, active_q, error_q;

    logic [15:0] shift_d;
    logic [3:0]  tmo_d;
    logic        key_legal, time_ok;

    assign key_legal = key_valid && (key <= MAX_DIGIT);
    assign shift_d   = {buf_q[11:0], key};
    assign tmo_d     = tmo_q + 4'd1;

    bcd_time_check u_check (
        .bcd_i   (buf_q),
        .valid_o (time_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            buf_q        <= MIDNIGHT;
            set_data_q   <= MIDNIGHT;
            digits_q     <= 3'd0;
            tmo_q        <= 4'd0;
            tgt_alarm_q  <= 1'b0;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            active_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            error_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_legal) begin
                        state_q  <= ST_ENTRY;
                        buf_q    <= {12'h000, key};
                        digits_q <= 3'd1;
                        tmo_q    <= 4'd0;
                        active_q <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    // Any exit back to IDLE drops the partial entry
                    if (clear_button) begin
                        state_q  <= ST_IDLE;
                        buf_q    <= MIDNIGHT;
                        digits_q <= 3'd0;
                        tmo_q    <= 4'd0;
                        active_q <= 1'b0;
                    end else if (time_button || alarm_button) begin
                        active_q <= 1'b0;
                        tmo_q    <= 4'd0;
                        if ((digits_q == 3'd4) && time_ok) begin
                            state_q     <= ST_COMMIT;
                            tgt_alarm_q <= !time_button;
                        end else begin
                            state_q  <= ST_IDLE;
                            buf_q    <= MIDNIGHT;
                            digits_q <= 3'd0;
                            error_q  <= 1'b1;
                        end
                    end else if (key_legal) begin
                        buf_q    <= shift_d;
                        digits_q <= (digits_q == 3'd4) ? 3'd4 : digits_q + 3'd1;
                        tmo_q    <= 4'd0;
                    end else if (one_second) begin
                        if (tmo_d == TIMEOUT_LIM) begin
                            state_q  <= ST_IDLE;
                            buf_q    <= MIDNIGHT;
                            digits_q <= 3'd0;
                            tmo_q    <= 4'd0;
                            active_q <= 1'b0;
                        end else begin
                            tmo_q <= tmo_d;
                        end
                    end
                end
                ST_COMMIT: begin
                    set_data_q   <= buf_q;
                    load_time_q  <= !tgt_alarm_q;
                    load_alarm_q <= tgt_alarm_q;
                    buf_q        <= MIDNIGHT;
                    digits_q     <= 3'd0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    buf_q    <= MIDNIGHT;
                    digits_q <= 3'd0;
                    tmo_q    <= 4'd0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_buffer   = buf_q;
    assign set_data     = set_data_q;
    assign load_time    = load_time_q;
    assign load_alarm   = load_alarm_q;
    assign entry_active = active_q;
    assign entry_error  = error_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader: loads, range rejects, timeout, priority and reset-in-commit.
module tb_time_entry_loader;

    logic        clk = 1'b0;
    logic        reset, one_second, key_valid;
    logic        time_button, alarm_button, clear_button;
    logic [3:0]  key;
    logic [15:0] key_buffer, set_data;
    logic        load_time, load_alarm, entry_active, entry_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    time_entry_loader #(.TIMEOUT_SEC(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .one_second   (one_second),
        .key          (key),
        .key_valid    (key_valid),
        .time_button  (time_button),
        .alarm_button (alarm_button),
        .clear_button (clear_button),
        .key_buffer   (key_buffer),
        .set_data     (set_data),
        .load_time    (load_time),
        .load_alarm   (load_alarm),
        .entry_active (entry_active),
        .entry_error  (entry_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key = k; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic tick();
        one_second = 1'b1;
        step();
        one_second = 1'b0;
    endtask

    task automatic check_strobes(input string tag, input logic lt, input logic la, input logic er);
        check({tag, "_load_time"},  {15'd0, load_time},  {15'd0, lt});
        check({tag, "_load_alarm"}, {15'd0, load_alarm}, {15'd0, la});
        check({tag, "_error"},      {15'd0, entry_error}, {15'd0, er});
    endtask

    initial begin
        reset = 1'b1; one_second = 1'b0; key_valid = 1'b0; key = 4'd0;
        time_button = 1'b0; alarm_button = 1'b0; clear_button = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_key_buffer", key_buffer, 16'h0000);
        check("rst_set_data", set_data, 16'h0000);
        check("rst_active", {15'd0, entry_active}, 16'd0);
        check_strobes("rst", 1'b0, 1'b0, 1'b0);

        // 1: valid time load
        press(4'd1);
        check("t1_first_key", key_buffer, 16'h0001);
        check("t1_active", {15'd0, entry_active}, 16'd1);
        press(4'd2); press(4'd3); press(4'd4);
        check("t1_buffer", key_buffer, 16'h1234);
        time_button = 1'b1; step(); time_button = 1'b0;
        check_strobes("t1_commit_cycle", 1'b0, 1'b0, 1'b0);
        check("t1_commit_active", {15'd0, entry_active}, 16'd0);
        step();
        check_strobes("t1_load", 1'b1, 1'b0, 1'b0);
        check("t1_set_data", set_data, 16'h1234);
        check("t1_buf_cleared", key_buffer, 16'h0000);
        step();
        check_strobes("t1_after", 1'b0, 1'b0, 1'b0);
        check("t1_set_data_hold", set_data, 16'h1234);

        // 2: out-of-range hours and minutes
        press(4'd2); press(4'd4); press(4'd0); press(4'd0);
        time_button = 1'b1; step(); time_button = 1'b0;
        check_strobes("t2_h24", 1'b0, 1'b0, 1'b1);
        check("t2_h24_active", {15'd0, entry_active}, 16'd0);
        check("t2_h24_buf", key_buffer, 16'h0000);
        step();
        check_strobes("t2_h24_after", 1'b0, 1'b0, 1'b0);
        check("t2_set_data", set_data, 16'h1234);
        press(4'd0); press(4'd9); press(4'd6); press(4'd0);
        time_button = 1'b1; step(); time_button = 1'b0;
        check_strobes("t2_m60", 1'b0, 1'b0, 1'b1);
        step();
        check_strobes("t2_m60_after", 1'b0, 1'b0, 1'b0);

        // 3: short entry then five-digit alarm entry
        press(4'd1); press(4'd2); press(4'd3);
        alarm_button = 1'b1; step(); alarm_button = 1'b0;
        check_strobes("t3_short", 1'b0, 1'b0, 1'b1);
        press(4'd9); press(4'd2); press(4'd3); press(4'd5); press(4'd9);
        check("t3_shift_buffer", key_buffer, 16'h2359);
        alarm_button = 1'b1; step(); alarm_button = 1'b0;
        step();
        check_strobes("t3_load", 1'b0, 1'b1, 1'b0);
        check("t3_set_data", set_data, 16'h2359);
        step();
        check_strobes("t3_after", 1'b0, 1'b0, 1'b0);

        // 4: timeout, then a key at strobe 9 restarts the count
        press(4'd5);
        for (int i = 0; i < 9; i++) tick();
        check("t4_before_timeout", {15'd0, entry_active}, 16'd1);
        tick();
        check("t4_timeout_active", {15'd0, entry_active}, 16'd0);
        check("t4_timeout_buf", key_buffer, 16'h0000);
        check_strobes("t4_timeout", 1'b0, 1'b0, 1'b0);
        press(4'd5);
        for (int i = 0; i < 8; i++) tick();
        key = 4'd6; key_valid = 1'b1; one_second = 1'b1;
        step();
        key_valid = 1'b0; one_second = 1'b0;
        check("t4_key_wins", key_buffer, 16'h0056);
        tick();
        check("t4_still_entry", {15'd0, entry_active}, 16'd1);
        press(4'hB);
        check("t4_illegal_key", key_buffer, 16'h0056);
        clear_button = 1'b1; step(); clear_button = 1'b0;
        check("t4_clear", {15'd0, entry_active}, 16'd0);

        // 5: simultaneous buttons
        press(4'd1); press(4'd2); press(4'd0); press(4'd0);
        time_button = 1'b1; alarm_button = 1'b1; step();
        time_button = 1'b0; alarm_button = 1'b0;
        step();
        check_strobes("t5_both", 1'b1, 1'b0, 1'b0);
        check("t5_set_data", set_data, 16'h1200);
        press(4'd0); press(4'd7); press(4'd3); press(4'd0);
        clear_button = 1'b1; time_button = 1'b1; step();
        clear_button = 1'b0; time_button = 1'b0;
        check("t5_clear_active", {15'd0, entry_active}, 16'd0);
        check_strobes("t5_clear", 1'b0, 1'b0, 1'b0);
        step();
        check_strobes("t5_clear_after", 1'b0, 1'b0, 1'b0);
        check("t5_set_data_hold", set_data, 16'h1200);

        // 6: reset during COMMIT, illegal key in IDLE
        press(4'd0); press(4'd8); press(4'd3); press(4'd0);
        time_button = 1'b1; step(); time_button = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check_strobes("t6_reset_commit", 1'b0, 1'b0, 1'b0);
        check("t6_set_data", set_data, 16'h0000);
        check("t6_buf", key_buffer, 16'h0000);
        check("t6_active", {15'd0, entry_active}, 16'd0);
        press(4'hA);
        check("t6_illegal_idle", {15'd0, entry_active}, 16'd0);
        check("t6_illegal_buf", key_buffer, 16'h0000);
        time_button = 1'b1; step(); time_button = 1'b0;
        step();
        check_strobes("t6_idle_button", 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
